// File: rtl/control_fsm.sv
// Multi-cycle RISC-V style control FSM with memory-wait timeout and sticky fault flags.
// Optional macro CONTROL_FSM_BNE_EN adds bne (funct3=001) branch handling in the BEQ state.
module control_fsm #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                illegal_q, illegal_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                wait_last;
  logic                in_wait;

  // State and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      illegal_q     <= illegal_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next state; the counter holds cycles already stalled, so this cycle is the last allowed one
  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    mem_timeout_d = mem_timeout_q;
    wait_last     = (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));
    in_wait       = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

    case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_MEMREAD: state_d = S_MEMWB;
            default:   state_d = S_FETCH;
          endcase
        end else if (wait_last) begin
          state_d       = S_FAULT;
          mem_timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECR;
          OP_ITYP:      state_d = S_EXECI;
          OP_BR:        state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FAULT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:                 state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL:  state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:  state_d = S_FETCH;
      S_FAULT:                  state_d = S_FAULT;
      default:                  state_d = S_FAULT;
    endcase

    // Any state change clears the counter, which covers every entry into a wait state
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (in_wait && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Datapath controls; write strobes are forced low while reset is held
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;

    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        if (funct3 == 3'b000) begin
          PCWrite = zero;
        end
`ifdef CONTROL_FSM_BNE_EN
        else if (funct3 == 3'b001) begin
          PCWrite = ~zero;
        end
`endif
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase

    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign illegal     = illegal_q;
  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm (MAX_WAIT=4) covering the instruction flows, faults and resets.
module tb_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       illegal, mem_timeout;
  logic [3:0] state_o;

  int n_checks;
  int n_errors;

`ifdef CONTROL_FSM_BNE_EN
  localparam logic BNE_PCW = 1'b1;
`else
  localparam logic BNE_PCW = 1'b0;
`endif

  control_fsm #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .mem_timeout(mem_timeout),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse between edges; checks the forced state while rst_n is low
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_illegal", 32'(illegal), 32'd0);
    check_eq("rst_timeout", 32'(mem_timeout), 32'd0);
    check_eq("rst_strobes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int exp_st[6];
    int exp_rw[6];
    exp_st = '{0, 1, 2, 3, 4, 0};
    exp_rw = '{0, 0, 0, 0, 1, 0};
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    op        = 7'b0000011;
    funct3    = 3'b000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    do_reset();

    // lw with memory always ready
    check_eq("fetch_irwrite", 32'(IRWrite), 32'd1);
    check_eq("fetch_pcwrite", 32'(PCWrite), 32'd1);
    check_eq("fetch_alusrcb", 32'(ALUSrcB), 32'd2);
    check_eq("fetch_resultsrc", 32'(ResultSrc), 32'd2);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("lw_state%0d", i), 32'(state_o), 32'(exp_st[i]));
      check_eq($sformatf("lw_regwrite%0d", i), 32'(RegWrite), 32'(exp_rw[i]));
      if (i == 3) check_eq("lw_adrsrc", 32'(AdrSrc), 32'd1);
      if (i < 5) tick();
    end

    // sw with three stall cycles in MEMWRITE; completes on the last allowed cycle
    op = 7'b0100011;
    tick();
    tick();
    check_eq("sw_memadr", 32'(state_o), 32'd2);
    check_eq("sw_immsrc", 32'(ImmSrc), 32'd1);
    mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("sw_wait_state%0d", k), 32'(state_o), 32'd5);
      check_eq($sformatf("sw_wait_memwrite%0d", k), 32'(MemWrite), 32'd0);
      check_eq($sformatf("sw_wait_adrsrc%0d", k), 32'(AdrSrc), 32'd1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("sw_memwrite", 32'(MemWrite), 32'd1);
    tick();
    check_eq("sw_done_state", 32'(state_o), 32'd0);
    check_eq("sw_done_memwrite", 32'(MemWrite), 32'd0);
    check_eq("sw_no_timeout", 32'(mem_timeout), 32'd0);

    // beq taken then not taken
    op = 7'b1100011;
    funct3 = 3'b000;
    zero = 1'b1;
    tick();
    tick();
    check_eq("beq1_state", 32'(state_o), 32'd9);
    check_eq("beq1_pcwrite", 32'(PCWrite), 32'd1);
    check_eq("beq1_aluop", 32'(ALUOp), 32'd1);
    check_eq("beq1_alusrca", 32'(ALUSrcA), 32'd2);
    check_eq("beq_immsrc", 32'(ImmSrc), 32'd2);
    tick();
    zero = 1'b0;
    tick();
    tick();
    check_eq("beq0_state", 32'(state_o), 32'd9);
    check_eq("beq0_pcwrite", 32'(PCWrite), 32'd0);
    tick();

    // bne with zero=0
    funct3 = 3'b001;
    tick();
    tick();
    check_eq("bne_state", 32'(state_o), 32'd9);
    check_eq("bne_pcwrite", 32'(PCWrite), 32'(BNE_PCW));
    tick();
    funct3 = 3'b000;

    // jal
    op = 7'b1101111;
    tick();
    tick();
    check_eq("jal_state", 32'(state_o), 32'd10);
    check_eq("jal_pcwrite", 32'(PCWrite), 32'd1);
    check_eq("jal_alusrc", 32'({ALUSrcA, ALUSrcB}), 32'b0110);
    check_eq("jal_immsrc", 32'(ImmSrc), 32'd3);
    tick();
    check_eq("jal_aluwb", 32'(state_o), 32'd8);
    check_eq("jal_regwrite", 32'(RegWrite), 32'd1);
    tick();
    check_eq("jal_fetch", 32'(state_o), 32'd0);

    // R-type and I-type
    op = 7'b0110011;
    tick();
    tick();
    check_eq("execr_state", 32'(state_o), 32'd6);
    check_eq("execr_ctrl", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b100010);
    tick();
    tick();
    op = 7'b0010011;
    tick();
    tick();
    check_eq("execi_state", 32'(state_o), 32'd7);
    check_eq("execi_ctrl", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b100110);
    tick();
    check_eq("execi_aluwb", 32'(state_o), 32'd8);
    tick();

    // Reset mid-store aborts it with no strobe
    op = 7'b0100011;
    tick();
    tick();
    tick();
    check_eq("abort_pre_state", 32'(state_o), 32'd5);
    do_reset();

    // FETCH stalls 3 cycles, ready on the 4th: no fault
    mem_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("fw_state%0d", k), 32'(state_o), 32'd0);
      check_eq($sformatf("fw_irwrite%0d", k), 32'(IRWrite), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("fw4_irwrite", 32'(IRWrite), 32'd1);
    tick();
    check_eq("fw4_decode", 32'(state_o), 32'd1);
    check_eq("fw4_no_timeout", 32'(mem_timeout), 32'd0);
    do_reset();

    // FETCH stalls 4 cycles: timeout fault
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("to_state%0d", k), 32'(state_o), 32'd0);
      tick();
    end
    check_eq("to_fault", 32'(state_o), 32'd11);
    check_eq("to_flag", 32'(mem_timeout), 32'd1);
    check_eq("to_illegal", 32'(illegal), 32'd0);
    mem_ready = 1'b1;
    #1;
    check_eq("to_strobes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    tick();
    check_eq("to_hold", 32'(state_o), 32'd11);
    check_eq("to_flag_hold", 32'(mem_timeout), 32'd1);
    do_reset();

    // Illegal opcode
    op = 7'b1111111;
    tick();
    check_eq("ill_immsrc", 32'(ImmSrc), 32'd0);
    tick();
    check_eq("ill_state", 32'(state_o), 32'd11);
    check_eq("ill_flag", 32'(illegal), 32'd1);
    tick();
    tick();
    check_eq("ill_hold_state", 32'(state_o), 32'd11);
    check_eq("ill_hold_flag", 32'(illegal), 32'd1);
    check_eq("ill_strobes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
    do_reset();
    check_eq("post_rst_state", 32'(state_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
